// File: rtl/bcd_display_mux.sv
// Three-digit multiplexed 7-segment driver for a latched BCD value.
// Optional leading-zero blanking is selected by defining BCD_DISP_LZB_EN.
module bcd_display_mux #(
   parameter int REFRESH_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [11:0] bcd,
   input  logic        en,
   output logic [2:0]  an,
   output logic [6:0]  seg,
   output logic        err
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   logic [11:0]   value;
   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic [1:0]    idx_next;
   logic [3:0]    digit;
   logic          blank;
   logic [2:0]    an_next;
   logic [6:0]    seg_next;
   logic          tc;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = 7'h3F;
      endcase
   endfunction

   assign tc = (presc == PRESC_LAST);

   // Scan index sequencing; the unused code 3 recovers to 0 on the next cycle.
   always_comb begin
      idx_next = idx;
      case (idx)
         2'd0:    if (tc) idx_next = 2'd1;
         2'd1:    if (tc) idx_next = 2'd2;
         2'd2:    if (tc) idx_next = 2'd0;
         default: idx_next = 2'd0;
      endcase
   end

   always_comb begin
      digit   = 4'd0;
      blank   = 1'b0;
      an_next = 3'b111;
      case (idx)
         2'd0: begin
            digit   = value[3:0];
            an_next = 3'b110;
         end
         2'd1: begin
            digit   = value[7:4];
            an_next = 3'b101;
`ifdef BCD_DISP_LZB_EN
            blank   = (value[11:8] == 4'd0) && (value[7:4] == 4'd0);
`endif
         end
         2'd2: begin
            digit   = value[11:8];
            an_next = 3'b011;
`ifdef BCD_DISP_LZB_EN
            blank   = (value[11:8] == 4'd0);
`endif
         end
         default: begin
            digit   = 4'd0;
            an_next = 3'b111;
         end
      endcase
      seg_next = blank ? 7'h7F : seg_code(digit);
      if (!en || idx == 2'd3) begin
         an_next  = 3'b111;
         seg_next = 7'h7F;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= 12'h000;
         presc <= '0;
         idx   <= 2'd0;
         an    <= 3'b111;
         seg   <= 7'h7F;
         err   <= 1'b0;
      end else begin
         if (load) value <= bcd;
         presc <= tc ? '0 : presc + 1'b1;
         idx   <= idx_next;
         an    <= an_next;
         seg   <= seg_next;
         err   <= (value[3:0] > 4'd9) || (value[7:4] > 4'd9) || (value[11:8] > 4'd9);
      end
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with REFRESH_DIV=4; expected digit codes are hand-derived.
// Build with BCD_DISP_LZB_EN defined to check the blanking variant.
module tb_bcd_display_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [11:0] bcd;
   logic        en;
   logic [2:0]  an;
   logic [6:0]  seg;
   logic        err;

   int checks = 0;
   int errors = 0;
   int k = 0;   // edges since the last reset release

   bcd_display_mux #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .load(load), .bcd(bcd),
      .en(en), .an(an), .seg(seg), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Output at edge k shows index ((k-1)/4)%3: four edges per slot, one edge of latency.
   task automatic check_scan(input string tag, input logic [6:0] s_u, input logic [6:0] s_t,
                             input logic [6:0] s_h, input logic exp_err, input int n);
      int slot;
      for (int i = 0; i < n; i++) begin
         step();
         slot = ((k - 1) / 4) % 3;
         case (slot)
            0: begin check({tag, "_an"}, {13'd0, an}, 16'h6); check({tag, "_seg"}, {9'd0, seg}, {9'd0, s_u}); end
            1: begin check({tag, "_an"}, {13'd0, an}, 16'h5); check({tag, "_seg"}, {9'd0, seg}, {9'd0, s_t}); end
            default: begin check({tag, "_an"}, {13'd0, an}, 16'h3); check({tag, "_seg"}, {9'd0, seg}, {9'd0, s_h}); end
         endcase
         check({tag, "_err"}, {15'd0, err}, {15'd0, exp_err});
      end
   endtask

`ifdef BCD_DISP_LZB_EN
   localparam logic [6:0] Z_BLANK = 7'h7F;
`else
   localparam logic [6:0] Z_BLANK = 7'h40;
`endif

   initial begin
      rst = 1'b1; load = 1'b0; bcd = 12'h000; en = 1'b1;
      step(); step();
      check("rst_an",  {13'd0, an},  16'h7);
      check("rst_seg", {9'd0, seg},  16'h7F);
      check("rst_err", {15'd0, err}, 16'h0);

      // Idle scan after reset: value 0.
      rst = 1'b0; k = 0;
      check_scan("idle", 7'h40, Z_BLANK, Z_BLANK, 1'b0, 12);

      // Load 255 before edge 13; edge 13 still shows old units digit.
      load = 1'b1; bcd = 12'h255;
      step();
      load = 1'b0;
      check("lat_seg", {9'd0, seg}, 16'h40);
      check_scan("v255", 7'h12, 7'h12, 7'h24, 1'b0, 12);

      // Load 0A7 at edge 26: err rises at edge 27, tens shows dash.
      load = 1'b1; bcd = 12'h0A7;
      step();
      load = 1'b0;
      check("err_pre", {15'd0, err}, 16'h0);
      check_scan("v0a7", 7'h78, 7'h3F, Z_BLANK, 1'b1, 12);

      // Load 007 at edge 39: err still high at 39, clears at 40.
      load = 1'b1; bcd = 12'h007;
      step();
      load = 1'b0;
      check("err_hold", {15'd0, err}, 16'h1);
      check_scan("v007", 7'h78, Z_BLANK, Z_BLANK, 1'b0, 12);

      // Edge 52 is a terminal count; load 999 there, edge 53 shows tens = 9.
      load = 1'b1; bcd = 12'h999;
      step();
      load = 1'b0;
      check("tc_an", {13'd0, an}, 16'h6);
      check_scan("v999", 7'h10, 7'h10, 7'h10, 1'b0, 12);

      // Display disabled while 123 is captured (edges 65..68).
      en = 1'b0; load = 1'b1; bcd = 12'h123;
      step();
      load = 1'b0;
      check("dis_an",  {13'd0, an}, 16'h7);
      check("dis_seg", {9'd0, seg}, 16'h7F);
      for (int i = 0; i < 3; i++) begin
         step();
         check("dis_an",  {13'd0, an}, 16'h7);
         check("dis_seg", {9'd0, seg}, 16'h7F);
      end
      en = 1'b1;
      check_scan("v123", 7'h30, 7'h24, 7'h79, 1'b0, 12);

      // Edge 81 captures B00 (bad hundreds); reset at edge 82 while index is 2.
      load = 1'b1; bcd = 12'hB00;
      step();
      load = 1'b0; rst = 1'b1;
      step();
      check("mid_rst_an",  {13'd0, an},  16'h7);
      check("mid_rst_seg", {9'd0, seg},  16'h7F);
      check("mid_rst_err", {15'd0, err}, 16'h0);
      rst = 1'b0; k = 0;
      check_scan("restart", 7'h40, Z_BLANK, Z_BLANK, 1'b0, 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout k=%0d", k);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter: REFRESH_DIV, default 1000, clk cycles per digit slot (legal range >= 2).
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: load  input  1  one-cycle pulse; captures bcd (driven by converter done_tick).
REQ-005 Port: bcd  input  12  three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 Port: en  input  1  display enable; 0 blanks all anodes.
REQ-007 Port: an  output  3  active-low anode select: [0] units, [1] tens, [2] hundreds.
REQ-008 Port: seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-009 Port: err  output  1  high while the latched value contains any digit > 9.

Function
REQ-010 The block SHALL hold a 12-bit value register, written from bcd on the clock edge where load=1, and otherwise retained.
REQ-011 load SHALL be captured regardless of en.
REQ-012 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; on its terminal count the digit index SHALL advance 0->1->2->0.
REQ-013 Index 3 SHALL never occur; if reached, the next cycle SHALL force index 0.
REQ-014 an and seg SHALL be registered: each edge loads them from the current index and value register (one-cycle output latency).
REQ-015 With en=1, an SHALL be 3'b110, 3'b101 or 3'b011 for index 0, 1 or 2; with en=0, an=3'b111 and seg=7'h7F.
REQ-016 Segment codes: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex); digit >9 SHALL show dash 7'h3F.
REQ-017 err SHALL be registered from the value register (asserted 1 cycle after the capturing edge).
REQ-018 Load and index advance on the same edge SHALL both take effect; the next seg update uses the new value.
REQ-019 A load pulse held high for several cycles SHALL re-capture bcd on each of those cycles; the last captured value wins.
REQ-020 Latency: load at edge N -> seg reflects the new value at edge N+1 for the active digit.

Reset
REQ-021 On rst=1 at a clock edge: value register 0, prescaler 0, index 0, an=3'b111, seg=7'h7F, err=0.
REQ-022 rst SHALL take priority over load and en; reset mid-scan SHALL restart the scan at index 0 with prescaler 0.
REQ-023 The first edge after rst deasserts with en=1 SHALL drive an=3'b110 and seg for units digit 0 (7'h40, or per REQ-025).

Configuration
REQ-024 Macro BCD_DISP_LZB_EN SHALL select leading-zero blanking.
REQ-025 Defined: hundreds blanked (seg=7'h7F, anode still active) when hundreds=0; tens blanked when hundreds=0 and tens=0; units never blanked.
REQ-026 Not defined: all three digits always displayed per REQ-016, no blanking logic synthesised.

Verification (REFRESH_DIV=4)
REQ-027 Reset, en=1, no load -> an cycles 110,101,011 every 4 clocks; seg=40 for all (no LZB) or 7F on tens/hundreds (LZB).
REQ-028 load with bcd=12'h255 -> seg=12 (units), 12 (tens), 24 (hundreds); err=0.
REQ-029 load with bcd=12'h0A7 -> tens shows dash 3F, err=1 next cycle; then load 12'h007 -> err=0; with LZB, tens and hundreds 7F.
REQ-030 load asserted on a prescaler terminal-count edge with bcd=12'h999 -> first seg update on the new digit is 10.
REQ-031 en=0 with load 12'h123 -> an=111, seg=7F; en back to 1 -> digits 33... as 30,24,79 in scan order.
REQ-032 rst asserted mid-scan at index 2 -> next edge an=111, seg=7F, err=0; after release scan restarts at index 0.
